ram_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller that sits directly upstream and downstream of dual_port_ram.

---
 rtl/ram_fifo_ctrl_pkg.sv | 17 +
 rtl/fifo_wrap_ptr.sv | 19 +
 rtl/ram_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: read FSM encoding
// and the RAM depth derived from the address width.
package ram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RD   = 2'd1,
    OUT_VALID = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_W = 8;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// ADDR_W-bit RAM pointer with synchronous clear and increment enable; the
// binary counter wraps at DEPTH = 2**ADDR_W on its own.
module fifo_wrap_ptr #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // NOTE: registered state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (clr)      ptr <= '0;
    else if (inc) ptr <= ptr + ADDR_W'(1);
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller wrapped around dual_port_ram: pushes through
// the write port, fetches through the registered read port into out_data.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              valid_wr,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [DATA_W-1:0] data_wr,
  output logic              valid_rd,
  output logic [ADDR_W-1:0] addr_rd,
  input  logic [DATA_W-1:0] data_rd,
  output logic [ADDR_W:0]   level
);

  localparam int              DEPTH      = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              issue;

  assign in_ready = !rst && (level != LEVEL_FULL);
  assign push     = in_valid && in_ready;
  assign valid_wr = push;
  assign addr_wr  = wr_ptr;
  assign data_wr  = in_data;

  // A read may only be issued against words already counted in level, so a
  // word pushed this cycle is never fetched in the same cycle.
  // NOTE: issue gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    issue = 1'b0;
    if (!rst && level != '0) begin
      case (state)
        IDLE:      issue = 1'b1;
        OUT_VALID: issue = out_ready;
        default:   issue = 1'b0;
      endcase
    end
  end

  assign valid_rd = issue;
  assign addr_rd  = rd_ptr;

  fifo_wrap_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk (clk),
    .clr (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk (clk),
    .clr (rst),
    .inc (issue),
    .ptr (rd_ptr)
  );

  // NOTE: reset only clears control state; RAM contents are deliberately left
  // alone, since occupancy is defined entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else     level <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) state <= WAIT_RD;
        end
        WAIT_RD: begin
          out_data  <= data_rd;
          out_valid <= 1'b1;
          state     <= OUT_VALID;
        end
        OUT_VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= issue ? WAIT_RD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue-based reference model,
// a vector table for the single-word path and directed corner sequences.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       valid_wr;
  logic [7:0] addr_wr;
  logic [7:0] data_wr;
  logic       valid_rd;
  logic [7:0] addr_rd;
  logic [7:0] data_rd;
  logic [8:0] level;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .valid_wr  (valid_wr),
    .addr_wr   (addr_wr),
    .data_wr   (data_wr),
    .valid_rd  (valid_rd),
    .addr_rd   (addr_rd),
    .data_rd   (data_rd),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with a registered read port.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (valid_wr) mem[addr_wr] <= data_wr;
    if (valid_rd) data_rd <= mem[addr_rd];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words stored in RAM in arrival order, one fetch slot in
  // flight, one held output word, and push/issue counts as addresses.
  logic [7:0] m_q[$];
  bit         m_busy, m_hold;
  logic [7:0] m_fetch, m_out;
  int         m_wr, m_rd;
  bit         e_push, e_issue, e_in_ready;

  task automatic model_clear();
    m_q.delete();
    m_busy = 0; m_hold = 0; m_fetch = '0; m_out = '0; m_wr = 0; m_rd = 0;
  endtask

  // Apply inputs just after the falling edge and compare against the model.
  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy);
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    e_in_ready = !rst && (m_q.size() != DEPTH);
    e_push     = iv && e_in_ready;
    e_issue    = !rst && (m_q.size() != 0) && ((!m_busy && !m_hold) || (m_hold && ordy));
    if (!rst) begin
      check("in_ready", 32'(in_ready), 32'(e_in_ready));
      check("valid_wr", 32'(valid_wr), 32'(e_push));
      check("valid_rd", 32'(valid_rd), 32'(e_issue));
      check("level", 32'(level), m_q.size());
      check("out_valid", 32'(out_valid), 32'(m_hold));
      check("out_data", 32'(out_data), 32'(m_out));
      if (e_push) begin
        check("addr_wr", 32'(addr_wr), m_wr);
        check("data_wr", 32'(data_wr), 32'(id));
      end
      if (e_issue) check("addr_rd", 32'(addr_rd), m_rd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (m_hold && out_ready) m_hold = 0;
      if (m_busy) begin
        m_hold = 1; m_out = m_fetch; m_busy = 0;
      end
      if (e_issue) begin
        m_fetch = m_q.pop_front(); m_busy = 1; m_rd = (m_rd + 1) % DEPTH;
      end
      if (e_push) begin
        m_q.push_back(in_data); m_wr = (m_wr + 1) % DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin drive(1'b0, 8'h00, 1'b0); tick(); end
    rst = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       x_in_ready;
    logic       x_valid_wr;
    logic       x_valid_rd;
    logic       x_out_valid;
    logic [7:0] x_out_data;
    int         x_level;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, sent, recv, cyc, pi, po;
    bit saw_wrap;
    logic [7:0] exp_b;

    // Single push of A5 from empty, with the downstream always ready.
    vt[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    vt[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 0};

    model_clear();
    @(negedge clk);

    // Reset state.
    do_reset(2);
    drive(1'b0, 8'h00, 1'b0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid_wr", 32'(valid_wr), 32'd0);
    check("rst_valid_rd", 32'(valid_rd), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    tick();

    for (int i = 0; i < 5; i++) begin
      drive(vt[i].iv, vt[i].id, vt[i].ordy);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].x_in_ready));
      check($sformatf("vec%0d_valid_wr", i), 32'(valid_wr), 32'(vt[i].x_valid_wr));
      check($sformatf("vec%0d_valid_rd", i), 32'(valid_rd), 32'(vt[i].x_valid_rd));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].x_out_valid));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].x_out_data));
      check($sformatf("vec%0d_level", i), 32'(level), vt[i].x_level);
      if (i == 0) check("vec0_addr_wr", 32'(addr_wr), 32'd0);
      if (i == 1) check("vec1_addr_rd", 32'(addr_rd), 32'd0);
      tick();
    end

    // Fill to capacity with the output stalled, then drain in order.
    do_reset(1);
    for (int i = 0; i < 256; i++) begin drive(1'b1, 8'(i), 1'b0); tick(); end
    drive(1'b0, 8'h00, 1'b0);
    check("full_level_255", 32'(level), 32'd255);
    check("full_out_data0", 32'(out_data), 32'd0);
    tick();
    drive(1'b1, 8'hEE, 1'b0);
    check("full_accept_257", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 8'h77, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level_256", 32'(level), 32'd256);
    check("full_refuse_wr", 32'(valid_wr), 32'd0);
    tick();
    got = 0; cyc = 0;
    while (got < 257 && cyc < 1000) begin
      drive(1'b0, 8'h00, 1'b1);
      if (out_valid) begin
        exp_b = (got < 256) ? 8'(got) : 8'hEE;
        check("drain_order", 32'(out_data), 32'(exp_b));
        got++;
      end
      tick(); cyc++;
    end
    check("drain_count", got, 257);
    drive(1'b0, 8'h00, 1'b0);
    check("drain_level", 32'(level), 32'd0);
    tick();

    // Continuous push/pop of 300 words across the address wrap.
    do_reset(1);
    sent = 0; recv = 0; cyc = 0; saw_wrap = 0;
    while ((sent < 300 || recv < 300) && cyc < 2000) begin
      drive(sent < 300, 8'(sent), 1'b1);
      if (valid_wr && sent == 256 && addr_wr == 8'd0) saw_wrap = 1;
      if (e_push) sent++;
      if (out_valid) begin
        check("wrap_order", 32'(out_data), recv % 256);
        recv++;
      end
      tick(); cyc++;
    end
    check("wrap_recv_count", recv, 300);
    check("wrap_addr_wr", 32'(saw_wrap), 32'd1);

    // Simultaneous push and issue in OUT_VALID with level 3.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin drive(1'b1, 8'(8'h10 + i), 1'b0); tick(); end
    drive(1'b1, 8'h20, 1'b1);
    check("both_level_before", 32'(level), 32'd3);
    check("both_valid_wr", 32'(valid_wr), 32'd1);
    check("both_valid_rd", 32'(valid_rd), 32'd1);
    check("both_addr_differ", 32'(addr_rd != addr_wr), 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    check("both_level_after", 32'(level), 32'd3);
    tick();

    // Reset while a read is in flight, then confirm a fresh word comes out first.
    do_reset(1);
    for (int i = 0; i < 6; i++) begin drive(1'b1, 8'(8'h50 + i), 1'b0); tick(); end
    drive(1'b1, 8'h60, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 8'h3C, 1'b0);
    tick();
    got = 0; cyc = 0;
    while (got == 0 && cyc < 20) begin
      drive(1'b0, 8'h00, 1'b1);
      if (out_valid) begin
        check("mid_rst_first_word", 32'(out_data), 32'h3C);
        got++;
      end
      tick(); cyc++;
    end
    check("mid_rst_word_seen", got, 1);

    // Randomised traffic with shifting push/pop pressure and rare resets.
    pi = 50; po = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        pi = ($urandom_range(0, 2) == 0) ? 20 : (($urandom_range(0, 1) == 0) ? 50 : 95);
        po = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 90);
      end
      rst = ($urandom_range(0, 999) == 0);
      drive($urandom_range(0, 99) < pi, 8'($urandom), $urandom_range(0, 99) < po);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
